// File: rtl/ccc_lock_sequencer.sv
// Power-up and lock supervisor for 1..4 PF_CCC PLLs feeding the IOD bit-alignment datapath.
// Runs on the free-running reference clock; raw PLL_LOCK inputs are synchronised and filtered here.
module ccc_lock_sequencer #(
    parameter int NUM_PLL             = 2,
    parameter int LOCK_FILTER_CYCLES  = 16,
    parameter int PWRDN_CYCLES        = 8,
    parameter int LOCK_TIMEOUT_CYCLES = 256,
    parameter int MAX_RETRIES         = 3,
    parameter int RST_STAGGER_CYCLES  = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               ENABLE,
    input  logic               CLR_STICKY,
    input  logic [NUM_PLL-1:0] PLL_LOCK,
    output logic [NUM_PLL-1:0] PLL_POWERDOWN_N,
    output logic [NUM_PLL-1:0] FABRIC_RESET_N,
    output logic               ALL_LOCKED,
    output logic               LOCK_LOST_STICKY,
    output logic [1:0]         RETRY_CNT,
    output logic               FAULT,
    output logic [2:0]         STATE
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PWRDN     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    localparam int LAST_REL = (NUM_PLL - 1) * RST_STAGGER_CYCLES;
    localparam int TMAX_A   = (PWRDN_CYCLES > LOCK_TIMEOUT_CYCLES) ? PWRDN_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int TMAX     = (TMAX_A > LAST_REL) ? TMAX_A : LAST_REL;
    localparam int TW       = $clog2(TMAX) + 1;
    localparam int CW       = $clog2(LOCK_FILTER_CYCLES + 1);

    localparam logic [TW-1:0]      T_PWRDN_END = TW'(PWRDN_CYCLES - 1);
    localparam logic [TW-1:0]      T_TIMEOUT   = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]      T_LAST_REL  = TW'(LAST_REL);
    localparam logic [TW-1:0]      T_SAT       = {TW{1'b1}};
    localparam logic [CW-1:0]      C_FULL      = CW'(LOCK_FILTER_CYCLES);
    localparam logic [NUM_PLL-1:0] FAB_FIRST   = NUM_PLL'(1);
    localparam logic [1:0]         RETRY_LIMIT = 2'(MAX_RETRIES);

    logic [NUM_PLL-1:0] sync1_r;
    logic [NUM_PLL-1:0] sync2_r;
    logic [CW-1:0]      cnt_r [NUM_PLL];
    logic [NUM_PLL-1:0] filt_s;
    logic               all_filt_s;
    state_t             state_r;
    logic [TW-1:0]      timer_r;

    // Lock synchronisers and per-channel run-length filter counters.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1_r <= '0;
            sync2_r <= '0;
            for (int i = 0; i < NUM_PLL; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            sync1_r <= PLL_LOCK;
            sync2_r <= sync1_r;
            for (int i = 0; i < NUM_PLL; i++) begin
                if (!sync2_r[i]) begin
                    cnt_r[i] <= '0;
                end else if (cnt_r[i] != C_FULL) begin
                    cnt_r[i] <= cnt_r[i] + CW'(1);
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    // Filtered lock: gated by the synced bit so it falls in the same cycle as the input.
    always_comb begin
        filt_s = '0;
        for (int i = 0; i < NUM_PLL; i++) begin
            filt_s[i] = sync2_r[i] && (cnt_r[i] == C_FULL);
        end
    end

    assign all_filt_s = &filt_s;
    assign STATE      = state_r;

    // Sequencer FSM with phase timer and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r          <= ST_IDLE;
            timer_r          <= '0;
            PLL_POWERDOWN_N  <= '0;
            FABRIC_RESET_N   <= '0;
            ALL_LOCKED       <= 1'b0;
            LOCK_LOST_STICKY <= 1'b0;
            RETRY_CNT        <= 2'd0;
            FAULT            <= 1'b0;
        end else begin
            timer_r <= (timer_r == T_SAT) ? timer_r : timer_r + TW'(1);
            if (CLR_STICKY) begin
                LOCK_LOST_STICKY <= 1'b0;
            end
            if (!ENABLE) begin
                state_r         <= ST_IDLE;
                timer_r         <= '0;
                PLL_POWERDOWN_N <= '0;
                FABRIC_RESET_N  <= '0;
                ALL_LOCKED      <= 1'b0;
                RETRY_CNT       <= 2'd0;
                FAULT           <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r         <= ST_PWRDN;
                        timer_r         <= '0;
                        PLL_POWERDOWN_N <= '0;
                    end
                    ST_PWRDN: begin
                        if (timer_r == T_PWRDN_END) begin
                            state_r         <= ST_WAIT_LOCK;
                            timer_r         <= '0;
                            PLL_POWERDOWN_N <= '1;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        // A lock arriving on the timeout cycle still wins.
                        if (all_filt_s) begin
                            state_r        <= ST_RELEASE;
                            timer_r        <= '0;
                            FABRIC_RESET_N <= FAB_FIRST;
                        end else if (timer_r == T_TIMEOUT) begin
                            timer_r         <= '0;
                            PLL_POWERDOWN_N <= '0;
                            if (RETRY_CNT == RETRY_LIMIT) begin
                                state_r <= ST_FAULT;
                                FAULT   <= 1'b1;
                            end else begin
                                state_r   <= ST_PWRDN;
                                RETRY_CNT <= RETRY_CNT + 2'd1;
                            end
                        end
                    end
                    ST_RELEASE: begin
                        if (!all_filt_s) begin
                            state_r          <= ST_PWRDN;
                            timer_r          <= '0;
                            PLL_POWERDOWN_N  <= '0;
                            FABRIC_RESET_N   <= '0;
                            LOCK_LOST_STICKY <= 1'b1;
                        end else if (timer_r == T_LAST_REL) begin
                            state_r        <= ST_RUN;
                            timer_r        <= '0;
                            ALL_LOCKED     <= 1'b1;
                            RETRY_CNT      <= 2'd0;
                            FABRIC_RESET_N <= '1;
                        end else begin
                            for (int i = 1; i < NUM_PLL; i++) begin
                                if (timer_r == TW'(i * RST_STAGGER_CYCLES - 1)) begin
                                    FABRIC_RESET_N[i] <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_RUN: begin
                        if (!all_filt_s) begin
                            state_r          <= ST_PWRDN;
                            timer_r          <= '0;
                            PLL_POWERDOWN_N  <= '0;
                            FABRIC_RESET_N   <= '0;
                            ALL_LOCKED       <= 1'b0;
                            LOCK_LOST_STICKY <= 1'b1;
                        end
                    end
                    ST_FAULT: begin
                        PLL_POWERDOWN_N <= '0;
                        FABRIC_RESET_N  <= '0;
                        FAULT           <= 1'b1;
                    end
                    default: begin
                        state_r         <= ST_IDLE;
                        timer_r         <= '0;
                        PLL_POWERDOWN_N <= '0;
                        FABRIC_RESET_N  <= '0;
                        ALL_LOCKED      <= 1'b0;
                        FAULT           <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
